spike_event_buffer: RTL and testbench
=====================================

Name: spike_event_buffer

Overview:
- Downstream stage of the Izhikevich neuron core.
- Watches the core's voltage on every apply step and detects spikes with the same criterion the core uses to reset: voltage >= v_th.
- Timestamps each spike with a step counter and queues it in a first-word-fall-through FIFO with a valid/ready output for readout or routing logic.
- Counts and flags events dropped when the FIFO is full.

Parameters:
- N, 32, fixed-point word width (matches core).
- Q, 16, fractional bits (matches core).
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TSW, 16, timestamp/step-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- apply  in  1  same strobe that drives the core's apply; marks one neuron step.
- voltage  in  N  core voltage output, sampled when apply=1.
- v_th  in  N  spike threshold, same encoding as voltage.
- out_valid  out  1  FIFO head holds an event.
- out_ready  in  1  consumer accepts head this cycle.
- out_time  out  TSW  timestamp of head event; don't-care when out_valid=0.
- occupancy  out  $clog2(DEPTH)+1  number of stored events.
- spike  out  1  registered one-cycle pulse per detected spike, including dropped spikes.
- step_count  out  TSW  current step counter.
- overflow  out  1  sticky flag: at least one event dropped.
- drop_count  out  8  dropped events, saturating at 255.
- clear_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset: on rst=1 at a clk edge, all of the following are cleared and FIFO contents are discarded:
  - out_valid, occupancy, spike, step_count, overflow, drop_count = 0;
  - read and write pointers = 0.
- rst has priority over every other input, including mid-stream. apply in the reset cycle is ignored; no count, no event.
- Spike detect is combinational: hit = apply & (voltage >= v_th).
  - Compare uses the codebase fixed_point_cmp (eq|gt), so encoding and sign handling are identical to the core.
- Step counter:
  - step_count increments by 1 on every apply=1 cycle and wraps modulo 2^TSW.
  - An event's timestamp is the step_count value before that increment. The first apply after reset produces timestamp 0.
- Push: on hit, at the clk edge.
  - If space exists, write the timestamp to mem[wr_ptr] and advance wr_ptr.
  - Space exists when occupancy < DEPTH, or when occupancy == DEPTH and a pop happens the same cycle.
- Pop: out_valid & out_ready advances rd_ptr at the clk edge. out_ready while empty has no effect.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. This holds when full, and when empty is impossible (empty means no pop).
- FWFT timing:
  - out_valid = (occupancy != 0); out_time = mem[rd_ptr].
  - Latency from a hit at edge k: out_valid high in cycle k+1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. occupancy is tracked explicitly, so full and empty are unambiguous.
- Drop: hit with no space.
  - No write occurs.
  - overflow <= 1; drop_count increments, saturating at 255.
- clear_overflow: clears overflow and drop_count.
  - If a drop occurs in the same cycle, overflow = 1 and drop_count = 1 (set wins).
- spike <= hit, registered, for every hit whether stored or dropped.
- out_time is stable while out_valid=1 and out_ready=0.
- No other outputs change without apply, out_ready or clear_overflow.

Decomposition:
- Shared package snn_pkg:
  - typedef logic [TSW-1:0] timestamp_t;
  - default constants SNN_N=32, SNN_Q=16, SPIKE_FIFO_DEPTH=16.
- One natural sub-module: sync_fifo_fwft, parameterised by width and depth.
  - Provides push, pop, dout, count, full, empty.
  - Does not handle drop or overflow policy.
- spike_event_buffer contains:
  - the fixed_point_cmp instance;
  - the step counter;
  - the drop/overflow logic.

Test Plan:
- Reset, then 5 apply cycles with voltage=0xFFB00000 (-80.0) and v_th=0x001E0000 (30.0):
  - step_count=5, spike=0, out_valid=0, occupancy=0.
- Equality and latency check:
  - At apply #3 (timestamp 2), drive voltage=0x001E0000, exactly equal to threshold.
  - spike=1 for one cycle; next cycle out_valid=1 and out_time=2.
  - Pulse out_ready: out_valid=0, occupancy=0.
- Overflow and saturation:
  - Hold out_ready=0 and spike on 20 consecutive applies, starting from timestamp 0.
  - occupancy=16 and overflow=1, drop_count=4.
  - Drain: out_time sequence is 0..15.
  - Then pulse clear_overflow: overflow=0, drop_count=0.
- Full FIFO with simultaneous push and pop, spike on the same cycle as out_ready=1:
  - occupancy stays 16, no drop.
  - The new timestamp appears after the 15 older entries.
- Wrap-around:
  - Set TSW=4; run 18 applies with spikes at applies 15 and 17.
  - out_time=14, then 0.
  - Pointers wrap cleanly over more than DEPTH pushes and pops.
- Reset mid-operation:
  - With occupancy=7 and overflow=1, assert rst while apply=1 and hit=1.
  - Next cycle all outputs are 0 and no event is stored.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron datapath blocks.
package snn_pkg;

    localparam int SNN_N            = 32;
    localparam int SNN_Q            = 16;
    localparam int SNN_TSW          = 16;
    localparam int SPIKE_FIFO_DEPTH = 16;

    typedef logic [SNN_TSW-1:0] timestamp_t;

endpackage : snn_pkg

// File: rtl/fixed_point_cmp.sv
// Signed two's-complement fixed-point comparator shared with the neuron core.
module fixed_point_cmp #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         gt
);

    // Fractional bits do not affect ordering, so only the word width matters here.
    assign eq = (a == b);
    assign gt = ($signed(a) > $signed(b));

endmodule : fixed_point_cmp

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy count.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : sync_fifo_fwft

// File: rtl/spike_event_buffer.sv
// Detects neuron spikes on apply steps, timestamps them and queues them for readout,
// counting events lost to a full queue.
module spike_event_buffer
    import snn_pkg::*;
#(
    parameter int N     = SNN_N,
    parameter int Q     = SNN_Q,
    parameter int DEPTH = SPIKE_FIFO_DEPTH,
    parameter int TSW   = SNN_TSW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   apply,
    input  logic [N-1:0]           voltage,
    input  logic [N-1:0]           v_th,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TSW-1:0]         out_time,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   spike,
    output logic [TSW-1:0]         step_count,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clear_overflow
);

    logic           cmp_eq;
    logic           cmp_gt;
    logic           hit;
    logic           pop;
    logic           push;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;

    logic [TSW-1:0] step_q,     step_d;
    logic           spike_q,    spike_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;

    // Same criterion the core uses to reset its membrane: voltage >= v_th.
    fixed_point_cmp #(
        .N (N)
    ) u_cmp (
        .a  (voltage),
        .b  (v_th),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    assign hit  = apply & (cmp_eq | cmp_gt);
    assign pop  = out_valid & out_ready;
    assign push = hit & (~fifo_full | pop);
    assign drop = hit & fifo_full & ~pop;

    sync_fifo_fwft #(
        .WIDTH (TSW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (step_q),
        .dout  (out_time),
        .count (occupancy),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;

    always_comb begin
        step_d     = step_q;
        spike_d    = hit;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (apply) step_d = step_q + 1'b1;

        // A drop in the clearing cycle wins: the flag stays set with one recorded drop.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)          drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q     <= '0;
            spike_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            step_q     <= step_d;
            spike_q    <= spike_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign step_count = step_q;
    assign spike      = spike_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule : spike_event_buffer

// File: tb/tb_spike_event_buffer.sv
// Directed and randomized checks of spike_event_buffer against a queue-based reference model.
module tb_spike_event_buffer;

    localparam int DEPTH = 16;
    localparam logic [31:0] V_LOW  = 32'hFFB0_0000;  // -80.0
    localparam logic [31:0] V_TH   = 32'h001E_0000;  //  30.0
    localparam logic [31:0] V_HIGH = 32'h0050_0000;  //  80.0

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        apply = 1'b0;
    logic [31:0] voltage = 32'd0;
    logic [31:0] v_th = V_TH;
    logic        out_ready = 1'b0;
    logic        clear_overflow = 1'b0;

    logic        out_valid_a, spike_a, overflow_a;
    logic [15:0] out_time_a, step_count_a;
    logic [4:0]  occupancy_a;
    logic [7:0]  drop_count_a;

    logic        out_valid_b, spike_b, overflow_b;
    logic [3:0]  out_time_b, step_count_b;
    logic [4:0]  occupancy_b;
    logic [7:0]  drop_count_b;

    int n_cmp  = 0;
    int n_fail = 0;

    spike_event_buffer #(.N(32), .Q(16), .DEPTH(DEPTH), .TSW(16)) dut_a (
        .clk(clk), .rst(rst), .apply(apply), .voltage(voltage), .v_th(v_th),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_time(out_time_a),
        .occupancy(occupancy_a), .spike(spike_a), .step_count(step_count_a),
        .overflow(overflow_a), .drop_count(drop_count_a), .clear_overflow(clear_overflow)
    );

    spike_event_buffer #(.N(32), .Q(16), .DEPTH(DEPTH), .TSW(4)) dut_b (
        .clk(clk), .rst(rst), .apply(apply), .voltage(voltage), .v_th(v_th),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_time(out_time_b),
        .occupancy(occupancy_b), .spike(spike_b), .step_count(step_count_b),
        .overflow(overflow_b), .drop_count(drop_count_b), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: event queue of full-width timestamps, masked per instance width.
    int  m_q[$];
    int  m_step = 0;
    bit  m_spike = 0;
    bit  m_ovf = 0;
    int  m_drop = 0;
    bit  m_hit;
    bit  started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_step  = 0;
            m_spike = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            m_hit = apply && ($signed(voltage) >= $signed(v_th));
            if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_hit && m_q.size() >= DEPTH) begin
                m_ovf  = 1;
                m_drop = clear_overflow ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else begin
                if (m_hit) m_q.push_back(m_step);
                if (clear_overflow) begin
                    m_ovf  = 0;
                    m_drop = 0;
                end
            end
            if (apply) m_step = (m_step + 1) % 65536;
            m_spike = m_hit;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid_a", int'(out_valid_a), int'(m_q.size() > 0));
            chk("occ_a",   int'(occupancy_a), m_q.size());
            chk("spike_a", int'(spike_a), int'(m_spike));
            chk("step_a",  int'(step_count_a), m_step);
            chk("ovf_a",   int'(overflow_a), int'(m_ovf));
            chk("drop_a",  int'(drop_count_a), m_drop);
            chk("valid_b", int'(out_valid_b), int'(m_q.size() > 0));
            chk("occ_b",   int'(occupancy_b), m_q.size());
            chk("step_b",  int'(step_count_b), m_step % 16);
            chk("drop_b",  int'(drop_count_b), m_drop);
            if (m_q.size() > 0) begin
                chk("time_a", int'(out_time_a), m_q[0]);
                chk("time_b", int'(out_time_b), m_q[0] % 16);
            end
        end
    end

    task automatic cyc(input bit r, input bit a, input logic [31:0] v,
                       input bit rdy, input bit clr);
        rst = r; apply = a; voltage = v; out_ready = rdy; clear_overflow = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        v_th = V_TH;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic hits(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 1, V_HIGH, rdy, 0);
    endtask

    initial begin
        int ready_pct;
        int sel;

        // Reset state and sub-threshold applies
        do_reset();
        chk("rst_valid", int'(out_valid_a), 0);
        chk("rst_occ", int'(occupancy_a), 0);
        chk("rst_step", int'(step_count_a), 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, V_LOW, 0, 0);
        chk("low_step", int'(step_count_a), 5);
        chk("low_spike", int'(spike_a), 0);
        chk("low_valid", int'(out_valid_a), 0);
        chk("low_occ", int'(occupancy_a), 0);

        // Equality at threshold and FWFT latency
        do_reset();
        cyc(0, 1, V_LOW, 0, 0);
        cyc(0, 1, V_LOW, 0, 0);
        cyc(0, 1, V_TH, 0, 0);
        chk("eq_spike", int'(spike_a), 1);
        chk("eq_valid", int'(out_valid_a), 1);
        chk("eq_time", int'(out_time_a), 2);
        cyc(0, 0, V_LOW, 0, 0);
        chk("eq_spike_off", int'(spike_a), 0);
        chk("eq_time_hold", int'(out_time_a), 2);
        cyc(0, 0, V_LOW, 1, 0);
        chk("eq_pop_valid", int'(out_valid_a), 0);
        chk("eq_pop_occ", int'(occupancy_a), 0);

        // Overflow, set-wins clear, drain order, clear
        do_reset();
        hits(20, 0);
        chk("ovf_occ", int'(occupancy_a), 16);
        chk("ovf_flag", int'(overflow_a), 1);
        chk("ovf_drops", int'(drop_count_a), 4);
        cyc(0, 1, V_HIGH, 0, 1);
        chk("setwins_flag", int'(overflow_a), 1);
        chk("setwins_drops", int'(drop_count_a), 1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_time", int'(out_time_a), i);
            cyc(0, 0, V_LOW, 1, 0);
        end
        chk("drain_occ", int'(occupancy_a), 0);
        cyc(0, 0, V_LOW, 0, 1);
        chk("clr_flag", int'(overflow_a), 0);
        chk("clr_drops", int'(drop_count_a), 0);

        // Drop-count saturation
        do_reset();
        hits(16 + 260, 0);
        chk("sat_drops", int'(drop_count_a), 255);

        // Full with simultaneous push and pop
        do_reset();
        hits(16, 0);
        cyc(0, 1, V_HIGH, 1, 0);
        chk("fullpp_occ", int'(occupancy_a), 16);
        chk("fullpp_ovf", int'(overflow_a), 0);
        for (int i = 1; i <= 16; i++) begin
            chk("fullpp_time", int'(out_time_a), i);
            cyc(0, 0, V_LOW, 1, 0);
        end

        // Timestamp wrap with a 4-bit counter
        do_reset();
        for (int a = 1; a <= 18; a++)
            cyc(0, 1, (a == 15 || a == 17) ? V_HIGH : V_LOW, 0, 0);
        chk("wrap_time_b0", int'(out_time_b), 14);
        chk("wrap_step_b", int'(step_count_b), 2);
        cyc(0, 0, V_LOW, 1, 0);
        chk("wrap_time_b1", int'(out_time_b), 0);
        chk("wrap_time_a1", int'(out_time_a), 16);
        cyc(0, 0, V_LOW, 1, 0);
        chk("wrap_empty", int'(out_valid_b), 0);

        // Reset mid-operation with a hit pending
        do_reset();
        hits(17, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, V_LOW, 1, 0);
        chk("mid_occ", int'(occupancy_a), 7);
        chk("mid_ovf", int'(overflow_a), 1);
        cyc(1, 1, V_HIGH, 0, 0);
        chk("mid_valid", int'(out_valid_a), 0);
        chk("mid_occ0", int'(occupancy_a), 0);
        chk("mid_spike", int'(spike_a), 0);
        chk("mid_step", int'(step_count_a), 0);
        chk("mid_ovf0", int'(overflow_a), 0);
        chk("mid_drops", int'(drop_count_a), 0);
        cyc(0, 0, V_LOW, 0, 0);
        chk("mid_nostore", int'(out_valid_a), 0);

        // Randomized traffic
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                sel = $urandom_range(0, 2);
                ready_pct = (sel == 0) ? 10 : (sel == 1) ? 50 : 90;
            end
            if (i % 64 == 0) v_th = ($urandom_range(0, 1) == 0) ? V_TH : $urandom;
            sel = $urandom_range(0, 3);
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                (sel == 0) ? v_th : (sel == 1) ? v_th - 32'd1 :
                (sel == 2) ? v_th + 32'd1 : 32'($urandom),
                ($urandom_range(0, 99) < ready_pct),
                ($urandom_range(0, 19) == 0));
        end
        cyc(0, 0, V_LOW, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_spike_event_buffer
